// File: rtl/wb_commit_stage_if.sv
// Retiring-instruction bundle between the MEM stage (master) and the
// write-back commit stage (slave); ready/valid handshake plus payload.
interface wb_commit_stage_if #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   alu_res;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rd;
    logic              reg_wen;
    logic [1:0]        wb_sel;
    logic [2:0]        ld_funct3;

    modport master (
        output in_valid, alu_res, pc, imm, rd, reg_wen, wb_sel, ld_funct3,
        input  in_ready
    );

    modport slave (
        input  in_valid, alu_res, pc, imm, rd, reg_wen, wb_sel, ld_funct3,
        output in_ready
    );
endinterface

// File: rtl/wb_commit_stage.sv
// Write-back commit stage: selects ALU/load/PC+4/imm, extracts load lanes and
// issues a one-cycle register-file write. Optional load watchdog: WB_LOAD_TIMEOUT_EN.
module wb_commit_stage #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5
`ifdef WB_LOAD_TIMEOUT_EN
    , parameter int LD_TIMEOUT = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    wb_commit_stage_if.slave  mem,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_rvalid,
    input  logic              flush,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              busy
`ifdef WB_LOAD_TIMEOUT_EN
    , output logic            ld_timeout
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        COMMIT   = 2'd2
    } state_t;

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;
    localparam logic [1:0] SEL_IMM  = 2'b11;

    state_t            state, state_nxt;
    logic              accept, load_done, ld_expire;
    logic              commit_we;
    logic [REG_AW-1:0] cap_rd;
    logic              cap_wen;
    logic [2:0]        cap_off, cap_funct3;
    logic [XLEN-1:0]   direct_data;

    // Lane select truncates misaligned offsets to the access size.
    function automatic logic [63:0] load_extract(input logic [63:0] d,
                                                 input logic [2:0]  o,
                                                 input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] w;
        b = d[{o, 3'b000} +: 8];
        h = d[{o[2:1], 4'b0000} +: 16];
        w = d[{o[2], 5'b00000} +: 32];
        case (f3)
            3'b000:  return {{56{b[7]}}, b};
            3'b100:  return {56'd0, b};
            3'b001:  return {{48{h[15]}}, h};
            3'b101:  return {48'd0, h};
            3'b010:  return {{32{w[31]}}, w};
            3'b110:  return {32'd0, w};
            3'b011:  return d;
            default: return 64'd0;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

`ifdef WB_LOAD_TIMEOUT_EN
    logic [7:0] ld_cnt;
`endif

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        load_done = 1'b0;
        ld_expire = 1'b0;
        case (state)
            IDLE: begin
                if (mem.in_valid && !flush) begin
                    accept    = 1'b1;
                    state_nxt = (mem.wb_sel == SEL_LOAD) ? WAIT_MEM : COMMIT;
                end
            end
            WAIT_MEM: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (mem_rvalid) begin
                    load_done = 1'b1;
                    state_nxt = COMMIT;
                end
`ifdef WB_LOAD_TIMEOUT_EN
                else if (ld_cnt == 8'(LD_TIMEOUT - 1)) begin
                    ld_expire = 1'b1;
                    state_nxt = COMMIT;
                end
`endif
            end
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        direct_data = mem.alu_res;
        case (mem.wb_sel)
            SEL_PC4: direct_data = mem.pc + XLEN'(4);
            SEL_IMM: direct_data = mem.imm;
            default: direct_data = mem.alu_res;
        endcase
    end

    assign mem.in_ready = (state == IDLE);
    assign busy         = (state != IDLE);
    // Address/data are registered on COMMIT entry; flush can still veto the
    // enable during the COMMIT cycle itself, hence the late gating.
    assign rf_we        = (state == COMMIT) && commit_we && !flush;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_we  <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            cap_rd     <= '0;
            cap_wen    <= 1'b0;
            cap_off    <= '0;
            cap_funct3 <= '0;
        end else begin
            if (accept) begin
                cap_rd     <= mem.rd;
                cap_wen    <= mem.reg_wen;
                cap_off    <= mem.alu_res[2:0];
                cap_funct3 <= mem.ld_funct3;
                if (mem.wb_sel != SEL_LOAD) begin
                    rf_waddr  <= mem.rd;
                    rf_wdata  <= direct_data;
                    commit_we <= mem.reg_wen && (mem.rd != '0);
                end
            end
            if (load_done || ld_expire) begin
                rf_waddr  <= cap_rd;
                rf_wdata  <= load_done ? load_extract(mem_rdata, cap_off, cap_funct3) : '0;
                commit_we <= cap_wen && (cap_rd != '0);
            end
        end
    end

`ifdef WB_LOAD_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_cnt     <= '0;
            ld_timeout <= 1'b0;
        end else begin
            ld_timeout <= ld_expire;
            if (accept)
                ld_cnt <= '0;
            else if (state == WAIT_MEM && !mem_rvalid)
                ld_cnt <= ld_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_commit_stage.sv
// Self-checking bench for wb_commit_stage: a per-cycle expectation timeline is
// built from transaction-level rules and compared against the DUT every cycle.
module tb_wb_commit_stage;

    localparam int DEPTH = 8192;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] mem_rdata;
    logic        mem_rvalid;
    logic        flush;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        busy;
`ifdef WB_LOAD_TIMEOUT_EN
    logic        ld_timeout;
`endif

    wb_commit_stage_if #(.XLEN(64), .REG_AW(5)) mif ();

    wb_commit_stage #(.XLEN(64), .REG_AW(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem        (mif),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .flush      (flush),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .busy       (busy)
`ifdef WB_LOAD_TIMEOUT_EN
        , .ld_timeout (ld_timeout)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          chk_en   = 1'b0;
    bit          exp_busy   [DEPTH];
    bit          exp_we     [DEPTH];
    bit          exp_commit [DEPTH];
    bit          exp_to     [DEPTH];
    logic [4:0]  exp_waddr  [DEPTH];
    logic [63:0] exp_wdata  [DEPTH];
    logic [4:0]  hold_a = '0;
    logic [63:0] hold_d = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Load result from access size and signedness, not from lane muxing.
    function automatic logic [63:0] model_load(input logic [63:0] d, input logic [2:0] off,
                                               input logic [2:0] f3);
        int          size, base;
        logic [63:0] mask, v;
        if (f3 == 3'b111) return 64'd0;
        size = 1 << f3[1:0];
        base = (int'(off) / size) * size;
        mask = (size == 8) ? {64{1'b1}} : ((64'd1 << (8 * size)) - 64'd1);
        v    = (d >> (8 * base)) & mask;
        if (!f3[2] && size < 8 && v[8 * size - 1]) v = v | ~mask;
        return v;
    endfunction

    always @(negedge clk) begin
        if (chk_en && cyc < DEPTH) begin
            if (exp_commit[cyc]) begin
                hold_a = exp_waddr[cyc];
                hold_d = exp_wdata[cyc];
            end
            check("rf_we", rf_we, exp_we[cyc]);
            check("in_ready", mif.in_ready, !exp_busy[cyc]);
            check("busy", busy, exp_busy[cyc]);
            check("rf_waddr", rf_waddr, hold_a);
            check("rf_wdata", rf_wdata, hold_d);
`ifdef WB_LOAD_TIMEOUT_EN
            check("ld_timeout", ld_timeout, exp_to[cyc]);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic junk_fields();
        mif.alu_res   = {$urandom, $urandom};
        mif.pc        = {$urandom, $urandom};
        mif.imm       = {$urandom, $urandom};
        mif.rd        = 5'($urandom);
        mif.reg_wen   = 1'($urandom);
        mif.wb_sel    = 2'($urandom);
        mif.ld_funct3 = 3'($urandom);
    endtask

    // An idle cycle; with fl set, a valid instruction is offered but flushed.
    task automatic drive_idle(input bit fl);
        junk_fields();
        mif.in_valid = fl ? 1'($urandom) : 1'b0;
        flush        = fl;
        mem_rvalid   = 1'($urandom);
        mem_rdata    = {$urandom, $urandom};
    endtask

    task automatic idle_cycle(input bit fl);
        drive_idle(fl);
        step();
        drive_idle(1'b0);
    endtask

    // One instruction from an idle cycle. k: rvalid offset after the handshake
    // (loads). fl: offset at which flush is raised, 0 = none.
    task automatic do_txn(input logic [1:0] sel, input logic [63:0] alu, input logic [63:0] pc_v,
                          input logic [63:0] imm_v, input logic [4:0] rd_v, input logic wen,
                          input logic [2:0] f3, input logic [63:0] rdata, input int k, input int fl);
        int          c, span, wc, last;
        logic [63:0] d;
        c = cyc;
        mif.in_valid  = 1'b1;
        mif.alu_res   = alu;
        mif.pc        = pc_v;
        mif.imm       = imm_v;
        mif.rd        = rd_v;
        mif.reg_wen   = wen;
        mif.wb_sel    = sel;
        mif.ld_funct3 = f3;
        flush         = 1'b0;
        mem_rvalid    = 1'($urandom);
        mem_rdata     = {$urandom, $urandom};
        case (sel)
            2'b00:   d = alu;
            2'b01:   d = model_load(rdata, alu[2:0], f3);
            2'b10:   d = pc_v + 64'd4;
            default: d = imm_v;
        endcase
        span = (sel == 2'b01) ? k + 1 : 1;
        wc   = c + span;
        last = (fl > 0 && fl < span) ? c + fl : wc;
        for (int j = c + 1; j <= last; j++) exp_busy[j] = 1'b1;
        if (last == wc) begin
            exp_commit[wc] = 1'b1;
            exp_waddr[wc]  = rd_v;
            exp_wdata[wc]  = d;
            exp_we[wc]     = wen && (rd_v != 5'd0) && (fl != span);
        end
        for (int j = 1; j <= last - c; j++) begin
            step();
            junk_fields();
            mif.in_valid = 1'($urandom);
            flush        = (j == fl);
            if (sel == 2'b01 && j <= k) begin
                mem_rvalid = (j == k);
                mem_rdata  = (j == k) ? rdata : {$urandom, $urandom};
            end else begin
                mem_rvalid = 1'($urandom);
                mem_rdata  = {$urandom, $urandom};
            end
        end
        step();
        drive_idle(1'b0);
    endtask

    localparam logic [63:0] RD_PAT = 64'h8877_6655_4433_2211;

    initial begin
        int c;
        drive_idle(1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_rf_we", rf_we, 1'b0);
        check("rst_waddr", rf_waddr, 5'd0);
        check("rst_wdata", rf_wdata, 64'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_in_ready", mif.in_ready, 1'b1);
        rst    = 1'b0;
        chk_en = 1'b1;
        idle_cycle(1'b0);

        do_txn(2'b00, 64'h1234, 64'd0, 64'd0, 5'd5, 1'b1, 3'b000, 64'd0, 1, 0);
        check("alu_wdata", rf_wdata, 64'h1234);
        check("alu_waddr", rf_waddr, 5'd5);
        do_txn(2'b10, 64'h55, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 5'd6, 1'b1, 3'b000, 64'd0, 1, 0);
        check("pc4_wrap", rf_wdata, 64'd0);
        do_txn(2'b11, 64'h55, 64'd0, 64'hFFFF_FFFF_8000_0000, 5'd7, 1'b1, 3'b000, 64'd0, 1, 0);
        check("imm", rf_wdata, 64'hFFFF_FFFF_8000_0000);

        do_txn(2'b01, 64'h1007, 64'd0, 64'd0, 5'd10, 1'b1, 3'b000, RD_PAT, 3, 0);
        check("lb_o7", rf_wdata, 64'hFFFF_FFFF_FFFF_FF88);
        do_txn(2'b01, 64'h1007, 64'd0, 64'd0, 5'd11, 1'b1, 3'b100, RD_PAT, 3, 0);
        check("lbu_o7", rf_wdata, 64'h88);
        do_txn(2'b01, 64'h2002, 64'd0, 64'd0, 5'd12, 1'b1, 3'b001, RD_PAT, 3, 0);
        check("lh_o2", rf_wdata, 64'h4433);
        do_txn(2'b01, 64'h2003, 64'd0, 64'd0, 5'd12, 1'b1, 3'b001, RD_PAT, 2, 0);
        check("lh_o3_trunc", rf_wdata, 64'h4433);
        do_txn(2'b01, 64'h3004, 64'd0, 64'd0, 5'd13, 1'b1, 3'b010, RD_PAT, 3, 0);
        check("lw_o4", rf_wdata, 64'hFFFF_FFFF_8877_6655);
        do_txn(2'b01, 64'h3004, 64'd0, 64'd0, 5'd14, 1'b1, 3'b110, RD_PAT, 3, 0);
        check("lwu_o4", rf_wdata, 64'h8877_6655);
        do_txn(2'b01, 64'h4000, 64'd0, 64'd0, 5'd15, 1'b1, 3'b011, RD_PAT, 3, 0);
        check("ld", rf_wdata, RD_PAT);
        check("ld_waddr", rf_waddr, 5'd15);

        // rd=0: no write strobe, stage still drains
        do_txn(2'b00, 64'hDEAD, 64'd0, 64'd0, 5'd0, 1'b1, 3'b000, 64'd0, 1, 0);
        check("rd0_busy_after", busy, 1'b0);

        // Flush mid-wait, then a stale rvalid in IDLE
        do_txn(2'b01, 64'h0, 64'd0, 64'd0, 5'd20, 1'b1, 3'b011, RD_PAT, 5, 2);
        mem_rvalid = 1'b1;
        mem_rdata  = RD_PAT;
        step();
        drive_idle(1'b0);
        check("flush_wait_hold", rf_wdata, 64'hDEAD);
        // Flush coincident with rvalid
        do_txn(2'b01, 64'h0, 64'd0, 64'd0, 5'd21, 1'b1, 3'b011, RD_PAT, 3, 3);
        check("flush_rvalid_hold", rf_wdata, 64'hDEAD);
        // Flush during COMMIT and flush blocking an IDLE handshake
        do_txn(2'b00, 64'hBEEF, 64'd0, 64'd0, 5'd22, 1'b1, 3'b000, 64'd0, 1, 1);
        idle_cycle(1'b1);

`ifdef WB_LOAD_TIMEOUT_EN
        c = cyc;
        junk_fields();
        mif.in_valid = 1'b1;
        mif.wb_sel   = 2'b01;
        mif.rd       = 5'd7;
        mif.reg_wen  = 1'b1;
        flush        = 1'b0;
        mem_rvalid   = 1'b0;
        for (int j = c + 1; j <= c + 17; j++) exp_busy[j] = 1'b1;
        exp_commit[c + 17] = 1'b1;
        exp_waddr[c + 17]  = 5'd7;
        exp_wdata[c + 17]  = 64'd0;
        exp_we[c + 17]     = 1'b1;
        exp_to[c + 17]     = 1'b1;
        for (int j = 1; j <= 17; j++) begin
            step();
            junk_fields();
            mif.in_valid = 1'($urandom);
            mem_rvalid   = (j == 17) ? 1'($urandom) : 1'b0;
        end
        step();
        drive_idle(1'b0);
        check("timeout_wdata", rf_wdata, 64'd0);
        check("timeout_waddr", rf_waddr, 5'd7);
`else
        // Without the watchdog the stage simply waits until flushed.
        do_txn(2'b01, 64'h0, 64'd0, 64'd0, 5'd23, 1'b1, 3'b011, RD_PAT, 60, 40);
        check("long_wait_hold", rf_wdata, 64'hBEEF);
`endif

        // Asynchronous reset in the middle of a load wait
        do_txn(2'b00, 64'hCAFE, 64'd0, 64'd0, 5'd3, 1'b1, 3'b000, 64'd0, 1, 0);
        c = cyc;
        junk_fields();
        mif.in_valid = 1'b1;
        mif.wb_sel   = 2'b01;
        flush        = 1'b0;
        mem_rvalid   = 1'b0;
        exp_busy[c + 1] = 1'b1;
        step();
        mif.in_valid = 1'b0;
        #2;
        chk_en = 1'b0;
        rst    = 1'b1;
        #1;
        check("async_rst_we", rf_we, 1'b0);
        check("async_rst_waddr", rf_waddr, 5'd0);
        check("async_rst_wdata", rf_wdata, 64'd0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_ready", mif.in_ready, 1'b1);
        step();
        rst    = 1'b0;
        hold_a = '0;
        hold_d = '0;
        chk_en = 1'b1;
        drive_idle(1'b0);
        mem_rvalid = 1'b1;
        mem_rdata  = RD_PAT;
        step();
        drive_idle(1'b0);

        for (int t = 0; t < 200; t++) begin
            logic [1:0] sel;
            logic [4:0] rd_v;
            int         k, span, fl;
            sel  = 2'($urandom);
            rd_v = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            k    = $urandom_range(1, 12);
            span = (sel == 2'b01) ? k + 1 : 1;
            fl   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, span) : 0;
            do_txn(sel, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                   rd_v, 1'($urandom), 3'($urandom), {$urandom, $urandom}, k, fl);
            repeat ($urandom_range(0, 2)) idle_cycle(1'($urandom));
        end
        idle_cycle(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_commit_stage.md
Name: wb_commit_stage

Overview:
- Write-back end of the datapath: the point where results return to the register file, after operand-B selection feeds the ALU.
- Accepts one retiring instruction per handshake from the MEM stage.
- Selects the write-back source: ALU result, load data, PC+4 or immediate.
- Performs load lane extraction and sign/zero extension, waits for memory read data when needed, and issues a single-cycle register-file write.

Parameters:
- XLEN, 64, datapath width (only 64 supported)
- REG_AW, 5, register address width

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  MEM stage presents an instruction
- in_ready  output  1  stage can accept; handshake when in_valid && in_ready
- alu_res  input  64  ALU result; also the load address (bits [2:0] = byte offset)
- pc  input  64  instruction PC
- imm  input  64  immediate (LUI path)
- rd  input  5  destination register
- reg_wen  input  1  instruction writes rd
- wb_sel  input  2  00 ALU, 01 load, 10 PC+4, 11 imm
- ld_funct3  input  3  load type (RV64 funct3 encoding)
- mem_rdata  input  64  memory read data, aligned doubleword
- mem_rvalid  input  1  mem_rdata valid this cycle
- flush  input  1  synchronous kill of the held instruction
- rf_we  output  1  register-file write enable, one-cycle pulse
- rf_waddr  output  5  write address
- rf_wdata  output  64  write data
- busy  output  1  state != IDLE

Behaviour:
- FSM states:
  - IDLE: in_ready=1.
  - WAIT_MEM: in_ready=0.
  - COMMIT: in_ready=0.
- Handshake in IDLE:
  - Capture all inputs.
  - wb_sel=01 -> WAIT_MEM.
  - Otherwise -> COMMIT.
- Non-load latency: handshake at cycle N -> rf_we=1 in cycle N+1 -> IDLE at N+2. Throughput is one instruction per 2 cycles.
- WAIT_MEM:
  - Sample mem_rvalid each cycle, including the first cycle after the handshake.
  - When mem_rvalid=1, latch the extracted data -> COMMIT.
  - mem_rvalid is ignored in IDLE and COMMIT.
- COMMIT:
  - rf_we = captured reg_wen && rd!=0.
  - rf_waddr = captured rd.
  - rf_wdata = selected value.
  - Always -> IDLE next cycle.
- Outputs are registered. Outside COMMIT: rf_we=0 and rf_waddr/rf_wdata hold their last values.
- Source select:
  - ALU: alu_res.
  - PC+4: pc+4 modulo 2^64.
  - imm: imm.
- Load extraction (o = captured alu_res[2:0]):
  - 000 LB: byte at o, sign-extended.
  - 100 LBU: byte at o, zero-extended.
  - 001 LH: halfword at o[2:1], sign-extended.
  - 101 LHU: halfword at o[2:1], zero-extended.
  - 010 LW: word at o[2], sign-extended.
  - 110 LWU: word at o[2], zero-extended.
  - 011 LD: full doubleword.
  - 111: result 0.
  - Misaligned offsets are truncated to natural alignment.
- flush:
  - In WAIT_MEM or COMMIT: next state IDLE and no rf_we; flush overrides COMMIT's write.
  - In IDLE: blocks that cycle's handshake.
  - Coincident with mem_rvalid: flush wins.
- rst (any state, mid-load included): state=IDLE, rf_we=0, rf_waddr=0, rf_wdata=0, busy=0, in_ready=1 after release. Any pending load is discarded.

Optional Feature:
- Macro WB_LOAD_TIMEOUT_EN.
- When defined:
  - Adds output ld_timeout (1 bit) and parameter LD_TIMEOUT, default 16.
  - An 8-bit counter clears on entry to WAIT_MEM and increments each WAIT_MEM cycle without mem_rvalid.
  - When the count reaches LD_TIMEOUT-1 with no mem_rvalid: go to COMMIT with data 0 and pulse ld_timeout for one cycle, coincident with rf_we.
  - ld_timeout resets to 0.
- When undefined: no port, no counter, and WAIT_MEM waits indefinitely.

Test Plan:
- Reset, then ALU op: alu_res=64'h1234, rd=5, reg_wen=1, wb_sel=00, handshake at cycle 3 -> rf_we=1, waddr=5, wdata=64'h1234 in cycle 4 only; in_ready low in cycle 4, high in cycle 5.
- PC+4 and imm: pc=64'hFFFF_FFFF_FFFF_FFFC, wb_sel=10 -> wdata=0. imm=64'hFFFF_FFFF_8000_0000, wb_sel=11 -> that value.
- Loads with mem_rdata=64'h8877_6655_4433_2211 and mem_rvalid three cycles after the handshake:
  - LB, o=7 -> FFFF_FFFF_FFFF_FF88.
  - LBU, o=7 -> 88.
  - LH, o=2 -> 4433.
  - LW, o=4 -> FFFF_FFFF_8877_6655.
  - LWU, o=4 -> 8877_6655.
  - LD -> full value.
  - Each writes in the cycle after rvalid.
- rd=0 with reg_wen=1 -> no rf_we; FSM still returns to IDLE.
- Flush: flush during WAIT_MEM -> no write, IDLE next cycle, later rvalid ignored. flush coincident with rvalid -> no write.
- Async rst asserted mid-WAIT_MEM between clock edges -> outputs 0 immediately. With WB_LOAD_TIMEOUT_EN and no rvalid -> write of 0 with ld_timeout=1, 17 cycles after the handshake.
